emib_burst_reader: RTL and testbench

EMIB_BURST_READER -- requirements
Module: emib_burst_reader

---
 rtl/emib_burst_reader.sv | 166 ++++++++++++++++
 tb/tb_emib_burst_reader.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emib_burst_reader.sv
// EMIB burst reader: fetches len words from start = base + offset over a fixed-latency
// RAM port into a first-word-fall-through FIFO. Optional macro EMIB_RD_LEN_CHECK_EN rejects len > MAX_LEN.
module emib_burst_reader #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int FIFO_AW = 8,
  parameter int RD_LAT  = 3,
  parameter int MAX_LEN = 256
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_rd_en,
  input  logic               i_error,
  input  logic [ADDR_W-1:0]  i_base_addr,
  input  logic [ADDR_W-1:0]  i_offset_addr,
  input  logic [ADDR_W-1:0]  i_len,
  output logic               o_ram_rd_en,
  output logic [ADDR_W-1:0]  o_ram_addr,
  input  logic [DATA_W-1:0]  i_ram_data,
  input  logic               i_rsp_en,
  output logic               o_rsp_valid,
  output logic [DATA_W-1:0]  o_rsp_data,
  output logic               o_busy,
  output logic               o_read_done,
  output logic               o_read_error,
  output logic [ADDR_W-1:0]  o_len,
  output logic [FIFO_AW:0]   o_fifo_level
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 5;

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, DRAIN, DONE, ERR} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   start_reg, len_reg, ptr_reg, len_out_reg;
  logic [RD_LAT-1:0]   vld_pipe_reg;
  logic [3:0]          inflight;
  logic [CW-1:0]       credit_sum;
  logic                can_issue, last_issue, len_err;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   head_reg;
  logic [FIFO_AW-1:0]  wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [FIFO_AW:0]    level_reg;
  logic                push, pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + 4'(vld_pipe_reg[i]);
  end

  // Reads still in the RAM pipe already own a FIFO slot, so the FIFO cannot overflow.
  assign credit_sum = CW'(level_reg) + CW'(inflight);
  assign can_issue  = credit_sum < CW'(DEPTH);
  assign last_issue = (ptr_reg == len_reg - ADDR_W'(1));

`ifdef EMIB_RD_LEN_CHECK_EN
  assign len_err = (len_reg > ADDR_W'(MAX_LEN));
`else
  // MAX_LEN is never negative, so this compiles to a constant 0.
  assign len_err = (MAX_LEN < 0);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (i_rd_en) state_next = CHECK;
      CHECK: begin
        if (i_error || len_err)  state_next = ERR;
        else if (len_reg == '0)  state_next = DONE;
        else                     state_next = ISSUE;
      end
      ISSUE: if (o_ram_rd_en && last_issue) state_next = DRAIN;
      DRAIN: if (inflight == '0) state_next = DONE;
      DONE:  state_next = IDLE;
      ERR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_ram_rd_en  = 1'b0;
    o_ram_addr   = '0;
    o_read_done  = 1'b0;
    o_read_error = 1'b0;
    o_busy       = (state_reg != IDLE);
    case (state_reg)
      ISSUE: begin
        if (can_issue) begin
          o_ram_rd_en = 1'b1;
          o_ram_addr  = start_reg + ptr_reg;
        end
      end
      DONE:    o_read_done  = 1'b1;
      ERR:     o_read_error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      start_reg   <= '0;
      len_reg     <= '0;
      ptr_reg     <= '0;
      len_out_reg <= '0;
    end else begin
      if (state_reg == IDLE && i_rd_en) begin
        start_reg <= i_base_addr + i_offset_addr;
        len_reg   <= i_len;
        ptr_reg   <= '0;
      end else if (o_ram_rd_en) begin
        ptr_reg <= ptr_reg + ADDR_W'(1);
      end
      if (state_next == DONE)     len_out_reg <= len_reg;
      else if (state_next == ERR) len_out_reg <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_pipe_reg <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) vld_pipe_reg[i] <= vld_pipe_reg[i-1];
      vld_pipe_reg[0] <= o_ram_rd_en;
    end
  end

  assign push        = vld_pipe_reg[RD_LAT-1];
  assign pop         = i_rsp_en && (level_reg != '0);
  assign rd_ptr_next = pop ? rd_ptr_reg + FIFO_AW'(1) : rd_ptr_reg;

  // Registered head read with write bypass keeps first-word-fall-through on a block RAM.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_reg] <= i_ram_data;
    if (push && (wr_ptr_reg == rd_ptr_next)) head_reg <= i_ram_data;
    else                                     head_reg <= mem[rd_ptr_next];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
      rd_ptr_reg <= rd_ptr_next;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign o_rsp_valid  = (level_reg != '0);
  assign o_rsp_data   = o_rsp_valid ? head_reg : '0;
  assign o_fifo_level = level_reg;
  assign o_len        = len_out_reg;

endmodule

// File: tb/tb_emib_burst_reader.sv
// Scoreboard bench for emib_burst_reader: a fixed-latency RAM model answers every strobe,
// expected addresses and words are queued at stimulus time and popped as the DUT produces them.
module tb_emib_burst_reader;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int FIFO_AW = 2;
  localparam int RD_LAT  = 3;
  localparam int MAX_LEN = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rd_en = 1'b0;
  logic              error = 1'b0;
  logic              rsp_en = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] offset_addr = '0;
  logic [ADDR_W-1:0] len = '0;
  logic [DATA_W-1:0] ram_data = '0;

  logic              o_ram_rd_en, o_rsp_valid, o_busy, o_read_done, o_read_error;
  logic [ADDR_W-1:0] o_ram_addr, o_len;
  logic [DATA_W-1:0] o_rsp_data;
  logic [FIFO_AW:0]  o_fifo_level;
  logic [55:0]       all_out;

  emib_burst_reader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_AW(FIFO_AW), .RD_LAT(RD_LAT), .MAX_LEN(MAX_LEN)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_en(rd_en), .i_error(error),
    .i_base_addr(base_addr), .i_offset_addr(offset_addr), .i_len(len),
    .o_ram_rd_en(o_ram_rd_en), .o_ram_addr(o_ram_addr), .i_ram_data(ram_data),
    .i_rsp_en(rsp_en), .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
    .o_busy(o_busy), .o_read_done(o_read_done), .o_read_error(o_read_error),
    .o_len(o_len), .o_fifo_level(o_fifo_level)
  );

  assign all_out = {o_ram_rd_en, o_ram_addr, o_rsp_valid, o_rsp_data, o_busy,
                    o_read_done, o_read_error, o_len, o_fifo_level};

  always #5 clk = ~clk;

  int chk_cnt = 0, pass_cnt = 0;
  int cyc = 0, issue_cnt = 0, done_cnt = 0, err_cnt = 0, pop_cnt = 0;
  int first_issue = 0, last_issue = 0, max_level = 0;
  logic [ADDR_W-1:0] addr_q[$];
  logic [DATA_W-1:0] data_q[$];
  logic [ADDR_W-1:0] ram_pipe [RD_LAT+1];

  function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
    return a ^ 16'h5A3C;
  endfunction

  task automatic clear_stats();
    issue_cnt = 0; done_cnt = 0; err_cnt = 0; pop_cnt = 0; max_level = 0;
  endtask

  // One clock: mid-cycle RAM model and scoreboard, then step to just after the next edge.
  task automatic tick();
    logic [DATA_W-1:0] exp_v;
    @(negedge clk);
    cyc++;
    for (int i = RD_LAT; i > 0; i--) ram_pipe[i] = ram_pipe[i-1];
    ram_pipe[0] = o_ram_addr;
    ram_data = ram_word(ram_pipe[RD_LAT]);
    if (o_ram_rd_en) begin
      issue_cnt++;
      if (issue_cnt == 1) first_issue = cyc;
      last_issue = cyc;
      chk_cnt++;
      if (addr_q.size() == 0) $display("FAIL ram_addr: got read at %h, required no read", o_ram_addr);
      else begin
        exp_v = addr_q.pop_front();
        if (o_ram_addr !== exp_v) $display("FAIL ram_addr: got %h, required %h", o_ram_addr, exp_v);
        else pass_cnt++;
      end
    end
    if (o_rsp_valid && rsp_en) begin
      pop_cnt++;
      chk_cnt++;
      if (data_q.size() == 0) $display("FAIL rsp_data: got word %h, required none", o_rsp_data);
      else begin
        exp_v = data_q.pop_front();
        if (o_rsp_data !== exp_v) $display("FAIL rsp_data: got %h, required %h", o_rsp_data, exp_v);
        else pass_cnt++;
      end
    end
    if (!o_rsp_valid) begin
      chk_cnt++;
      if (o_rsp_data !== '0) $display("FAIL rsp_data_empty: got %h, required 0", o_rsp_data);
      else pass_cnt++;
    end
    if (o_read_done) done_cnt++;
    if (o_read_error) err_cnt++;
    if (int'(o_fifo_level) > max_level) max_level = int'(o_fifo_level);
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_xfer(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] o,
                            input logic [ADDR_W-1:0] l, input logic err, input bit expect_words);
    logic [ADDR_W-1:0] a;
    base_addr = b; offset_addr = o; len = l; error = err; rd_en = 1'b1;
    if (expect_words) begin
      for (int i = 0; i < int'(l); i++) begin
        a = b + o + ADDR_W'(i);
        addr_q.push_back(a);
        data_q.push_back(ram_word(a));
      end
    end
    tick();
    rd_en = 1'b0;
    tick();
    error = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (!o_busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    #2;
    chk_cnt++;
    if (all_out !== '0) $display("FAIL reset_outputs: got %h, required 0", all_out);
    else pass_cnt++;
    ticks(2);
    rst_n = 1'b1;
    tick();
    chk_cnt++;
    if (all_out !== '0) $display("FAIL idle_after_reset: got %h, required 0", all_out);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    bit ok;
    clear_stats();
    rsp_en = 1'b1;
    start_xfer(16'h0100, 16'h0010, 16'd4, 1'b0, 1'b1);
    chk_cnt++;
    if (o_ram_rd_en !== 1'b1 || issue_cnt != 0)
      $display("FAIL first_strobe: got rd_en=%b prior=%0d, required rd_en=1 prior=0", o_ram_rd_en, issue_cnt);
    else pass_cnt++;
    wait_idle(50, ok);
    chk_cnt++;
    if (!ok) $display("FAIL basic_timeout: got busy, required idle");
    else pass_cnt++;
    chk_cnt++;
    if (issue_cnt != 4 || last_issue - first_issue != 3)
      $display("FAIL basic_issue: got %0d reads over %0d cycles, required 4 over 3", issue_cnt, last_issue - first_issue);
    else pass_cnt++;
    chk_cnt++;
    if (done_cnt != 1 || o_len !== 16'd4)
      $display("FAIL basic_done: got done=%0d len=%0d, required done=1 len=4", done_cnt, o_len);
    else pass_cnt++;
    ticks(6);
    chk_cnt++;
    if (data_q.size() != 0 || pop_cnt != 4 || o_len !== 16'd4)
      $display("FAIL basic_drain: got left=%0d pops=%0d len=%0d, required 0 4 4", data_q.size(), pop_cnt, o_len);
    else pass_cnt++;
  endtask

  task automatic test_error();
    bit ok;
    logic [FIFO_AW:0] level_before;
    clear_stats();
    rsp_en = 1'b0;
    start_xfer(16'h1000, 16'h0000, 16'd2, 1'b0, 1'b1);
    wait_idle(50, ok);
    ticks(6);
    level_before = o_fifo_level;
    clear_stats();
    start_xfer(16'h1100, 16'h0000, 16'd5, 1'b1, 1'b0);
    chk_cnt++;
    if (o_read_error !== 1'b1 || o_len !== '0)
      $display("FAIL error_pulse: got err=%b len=%0d, required err=1 len=0", o_read_error, o_len);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (o_read_error !== 1'b0 || o_busy !== 1'b0 || err_cnt != 1 || done_cnt != 0)
      $display("FAIL error_end: got err=%b busy=%b errs=%0d dones=%0d, required 0 0 1 0", o_read_error, o_busy, err_cnt, done_cnt);
    else pass_cnt++;
    ticks(4);
    chk_cnt++;
    if (issue_cnt != 0 || o_fifo_level !== level_before || level_before !== 3'd2)
      $display("FAIL error_fifo: got reads=%0d level=%0d, required 0 reads level 2", issue_cnt, o_fifo_level);
    else pass_cnt++;
    rsp_en = 1'b1;
    ticks(4);
    chk_cnt++;
    if (data_q.size() != 0 || pop_cnt != 2)
      $display("FAIL error_keep_words: got left=%0d pops=%0d, required 0 2", data_q.size(), pop_cnt);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_stats();
    rsp_en = 1'b0;
    start_xfer(16'h2000, 16'h0000, 16'd10, 1'b0, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (o_fifo_level == 3'd4) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk_cnt++;
    if (!ok) $display("FAIL bp_fill: got level %0d, required 4", o_fifo_level);
    else pass_cnt++;
    ticks(10);
    chk_cnt++;
    if (o_fifo_level !== 3'd4 || issue_cnt != 4 || o_busy !== 1'b1 || max_level > 4)
      $display("FAIL bp_stall: got level=%0d reads=%0d busy=%b max=%0d, required 4 4 1 4", o_fifo_level, issue_cnt, o_busy, max_level);
    else pass_cnt++;
    rsp_en = 1'b1;
    wait_idle(100, ok);
    chk_cnt++;
    if (!ok || done_cnt != 1 || o_len !== 16'd10)
      $display("FAIL bp_done: got ok=%b done=%0d len=%0d, required 1 1 10", ok, done_cnt, o_len);
    else pass_cnt++;
    ticks(8);
    chk_cnt++;
    if (data_q.size() != 0 || pop_cnt != 10 || max_level > 4)
      $display("FAIL bp_drain: got left=%0d pops=%0d max=%0d, required 0 10 4", data_q.size(), pop_cnt, max_level);
    else pass_cnt++;
  endtask

  task automatic test_len_zero();
    clear_stats();
    start_xfer(16'h0300, 16'h0000, 16'd0, 1'b0, 1'b0);
    chk_cnt++;
    if (o_read_done !== 1'b1 || o_len !== '0 || o_busy !== 1'b1)
      $display("FAIL len0_done: got done=%b len=%0d busy=%b, required 1 0 1", o_read_done, o_len, o_busy);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (o_read_done !== 1'b0 || o_busy !== 1'b0 || issue_cnt != 0 || done_cnt != 1)
      $display("FAIL len0_end: got done=%b busy=%b reads=%0d dones=%0d, required 0 0 0 1", o_read_done, o_busy, issue_cnt, done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_len_limit();
    bit ok;
    clear_stats();
    rsp_en = 1'b1;
`ifdef EMIB_RD_LEN_CHECK_EN
    start_xfer(16'h0000, 16'h0000, 16'd257, 1'b0, 1'b0);
    chk_cnt++;
    if (o_read_error !== 1'b1 || o_len !== '0 || issue_cnt != 0)
      $display("FAIL len_limit: got err=%b len=%0d reads=%0d, required 1 0 0", o_read_error, o_len, issue_cnt);
    else pass_cnt++;
    tick();
`else
    start_xfer(16'h0000, 16'h0000, 16'd257, 1'b0, 1'b1);
    wait_idle(1500, ok);
    ticks(8);
    chk_cnt++;
    if (!ok || o_len !== 16'd257 || pop_cnt != 257 || data_q.size() != 0 || err_cnt != 0)
      $display("FAIL len_long: got ok=%b len=%0d pops=%0d errs=%0d, required 1 257 257 0", ok, o_len, pop_cnt, err_cnt);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_stats();
    rsp_en = 1'b1;
    start_xfer(16'h4000, 16'h0000, 16'd8, 1'b0, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (issue_cnt >= 3) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk_cnt++;
    if (!ok || o_busy !== 1'b1) $display("FAIL mid_issue: got reads=%0d busy=%b, required >=3 1", issue_cnt, o_busy);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (all_out !== '0) $display("FAIL mid_reset_outputs: got %h, required 0", all_out);
    else pass_cnt++;
    addr_q.delete();
    data_q.delete();
    ticks(2);
    rst_n = 1'b1;
    ticks(6);
    chk_cnt++;
    if (o_fifo_level !== '0 || o_rsp_valid !== 1'b0)
      $display("FAIL mid_stale: got level=%0d valid=%b, required 0 0", o_fifo_level, o_rsp_valid);
    else pass_cnt++;
    clear_stats();
    start_xfer(16'h4100, 16'h0000, 16'd2, 1'b0, 1'b1);
    wait_idle(50, ok);
    ticks(8);
    chk_cnt++;
    if (!ok || pop_cnt != 2 || data_q.size() != 0 || o_fifo_level !== '0)
      $display("FAIL mid_after: got ok=%b pops=%0d left=%0d level=%0d, required 1 2 0 0", ok, pop_cnt, data_q.size(), o_fifo_level);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    bit ok;
    clear_stats();
    rsp_en = 1'b1;
    start_xfer(16'hFFFE, 16'h0000, 16'd4, 1'b0, 1'b1);
    wait_idle(50, ok);
    ticks(8);
    chk_cnt++;
    if (!ok || issue_cnt != 4 || addr_q.size() != 0 || pop_cnt != 4 || data_q.size() != 0)
      $display("FAIL wrap: got ok=%b reads=%0d pops=%0d, required 1 4 4", ok, issue_cnt, pop_cnt);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_stats();
    rsp_en = 1'b0;
    start_xfer(16'h0500, 16'h0001, 16'd2, 1'b0, 1'b1);
    wait_idle(50, ok);
    start_xfer(16'h0600, 16'h0000, 16'd2, 1'b0, 1'b1);
    wait_idle(50, ok);
    ticks(6);
    chk_cnt++;
    if (!ok || o_fifo_level !== 3'd4 || done_cnt != 2)
      $display("FAIL b2b_fill: got ok=%b level=%0d dones=%0d, required 1 4 2", ok, o_fifo_level, done_cnt);
    else pass_cnt++;
    rsp_en = 1'b1;
    ticks(8);
    chk_cnt++;
    if (pop_cnt != 4 || data_q.size() != 0 || o_fifo_level !== '0)
      $display("FAIL b2b_order: got pops=%0d left=%0d level=%0d, required 4 0 0", pop_cnt, data_q.size(), o_fifo_level);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i <= RD_LAT; i++) ram_pipe[i] = '0;
    test_reset();
    test_basic();
    test_error();
    test_backpressure();
    test_len_zero();
    test_len_limit();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
